// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write bundle between a program source
// and the loader; the loader owns the slave side.
interface imem_loader_if #(
    parameter int ADDR_WIDTH = 9
) ();
    logic                  start;
    logic [7:0]            byte_in;
    logic                  byte_valid;
    logic                  byte_last;
    logic                  byte_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [7:0]            mem_data;
    logic [ADDR_WIDTH:0]   byte_count;
    logic                  load_done;
    logic                  pipe_hold;
    logic                  overflow;

    modport master (
        output start, byte_in, byte_valid, byte_last,
        input  byte_ready, mem_we, mem_addr, mem_data, byte_count,
               load_done, pipe_hold, overflow
    );

    modport slave (
        input  start, byte_in, byte_valid, byte_last,
        output byte_ready, mem_we, mem_addr, mem_data, byte_count,
               load_done, pipe_hold, overflow
    );
endinterface

// File: rtl/imem_loader.sv
// Fills instruction memory from a byte stream, pads the tail to a whole word
// and keeps the pipeline held until the image is complete.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no load since reset; waiting for start
// ST_LOAD  | accepting stream bytes, one write per transfer
// ST_PAD   | writing PAD_BYTE until the current word is complete
// ST_DONE  | image loaded and word-aligned; pipeline released
// ST_ERROR | stream ran past the end of memory without byte_last
module imem_loader #(
    parameter int          ADDR_WIDTH = 9,
    parameter int          DEPTH      = 512,
    parameter logic [7:0]  PAD_BYTE   = 8'h00
) (
    input  logic           clk,
    input  logic           reset,
    imem_loader_if.slave   bus
);
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_PAD   = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_ERROR = 3'd4;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    logic [2:0]            state;
    logic [ADDR_WIDTH-1:0] ptr;
    logic                  xfer;

    assign xfer            = bus.byte_valid && (state == ST_LOAD);
    assign bus.byte_ready  = (state == ST_LOAD);
    assign bus.load_done   = (state == ST_DONE);
    assign bus.pipe_hold   = (state != ST_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            ptr            <= '0;
            bus.byte_count <= '0;
            bus.mem_we     <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_data   <= '0;
            bus.overflow   <= 1'b0;
        end else begin
            bus.mem_we <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (bus.start) begin
                        state          <= ST_LOAD;
                        ptr            <= '0;
                        bus.byte_count <= '0;
                        bus.overflow   <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (xfer) begin
                        bus.mem_we     <= 1'b1;
                        bus.mem_addr   <= ptr;
                        bus.mem_data   <= bus.byte_in;
                        ptr            <= ptr + 1'b1;
                        bus.byte_count <= bus.byte_count + 1'b1;
                        // byte_last wins at the top address: a full-memory image is legal
                        if (bus.byte_last) begin
                            state <= (ptr[1:0] == 2'd3) ? ST_DONE : ST_PAD;
                        end else if (ptr == LAST_ADDR) begin
                            state        <= ST_ERROR;
                            bus.overflow <= 1'b1;
                        end
                    end
                end
                ST_PAD: begin
                    bus.mem_we   <= 1'b1;
                    bus.mem_addr <= ptr;
                    bus.mem_data <= PAD_BYTE;
                    ptr          <= ptr + 1'b1;
                    if (ptr[1:0] == 2'd3) begin
                        state <= ST_DONE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: each load is checked cycle by cycle
// against the expected image (stream bytes, then pad bytes to a word edge).
module tb_imem_loader;
    localparam int         ADDR_WIDTH = 9;
    localparam int         DEPTH      = 512;
    localparam logic [7:0] PAD_BYTE   = 8'h00;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   exp_addr = 0;
    logic [7:0] exp_data = 8'h00;

    imem_loader_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();

    imem_loader #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH),
        .PAD_BYTE   (PAD_BYTE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_we"},    32'(bus.mem_we), 0);
        chk({tag, "_addr"},  32'(bus.mem_addr), 0);
        chk({tag, "_data"},  32'(bus.mem_data), 0);
        chk({tag, "_cnt"},   32'(bus.byte_count), 0);
        chk({tag, "_hold"},  32'(bus.pipe_hold), 1);
        chk({tag, "_done"},  32'(bus.load_done), 0);
        chk({tag, "_ovf"},   32'(bus.overflow), 0);
        chk({tag, "_ready"}, 32'(bus.byte_ready), 0);
    endtask

    // gap < 0 toggles byte_valid every cycle; otherwise it is the idle percentage.
    // Without byte_last the load is expected to run into the end of memory.
    task automatic run_load(input int n, input bit with_last, input int gap);
        int         idx   = 0;
        int         guard = 0;
        bit         fin   = 1'b0;
        bit         xfer;
        bit         done_exp;
        bit         ovf_exp;
        int         pads;
        logic [7:0] b;

        bus.start      = 1'b1;
        bus.byte_valid = 1'b0;
        bus.byte_last  = 1'b0;
        tick();
        bus.start = 1'b0;
        chk("start_ready", 32'(bus.byte_ready), 1);
        chk("start_hold",  32'(bus.pipe_hold), 1);
        chk("start_done",  32'(bus.load_done), 0);
        chk("start_ovf",   32'(bus.overflow), 0);
        chk("start_cnt",   32'(bus.byte_count), 0);
        chk("start_we",    32'(bus.mem_we), 0);

        while (!fin && guard < 4000) begin
            guard++;
            bus.byte_valid = (gap < 0) ? guard[0] : ($urandom_range(99) >= 32'(gap));
            b              = 8'($urandom);
            bus.byte_in    = b;
            bus.byte_last  = with_last && (idx == n - 1);
            bus.start      = ($urandom_range(9) == 0);
            xfer           = bus.byte_valid;
            tick();
            if (xfer) begin
                exp_addr = idx;
                exp_data = b;
                idx++;
                if (with_last ? (idx == n) : (idx == DEPTH)) fin = 1'b1;
            end
            ovf_exp  = fin && !with_last;
            done_exp = fin && with_last && (n % 4 == 0);
            chk("ld_we",    32'(bus.mem_we), 32'(xfer));
            chk("ld_addr",  32'(bus.mem_addr), 32'(exp_addr));
            chk("ld_data",  32'(bus.mem_data), 32'(exp_data));
            chk("ld_cnt",   32'(bus.byte_count), 32'(idx));
            chk("ld_ready", 32'(bus.byte_ready), 32'(!fin));
            chk("ld_done",  32'(bus.load_done), 32'(done_exp));
            chk("ld_hold",  32'(bus.pipe_hold), 32'(!done_exp));
            chk("ld_ovf",   32'(bus.overflow), 32'(ovf_exp));
        end
        if (!fin) chk("ld_timeout_bytes", 32'(idx), 32'(n));

        pads = with_last ? (4 - n % 4) % 4 : 0;
        for (int k = 0; k < pads; k++) begin
            bus.byte_valid = 1'($urandom);
            bus.byte_last  = 1'($urandom);
            bus.start      = ($urandom_range(4) == 0);
            tick();
            exp_addr = n + k;
            exp_data = PAD_BYTE;
            done_exp = (k == pads - 1);
            chk("pad_we",    32'(bus.mem_we), 1);
            chk("pad_addr",  32'(bus.mem_addr), 32'(exp_addr));
            chk("pad_data",  32'(bus.mem_data), 32'(exp_data));
            chk("pad_cnt",   32'(bus.byte_count), 32'(n));
            chk("pad_ready", 32'(bus.byte_ready), 0);
            chk("pad_done",  32'(bus.load_done), 32'(done_exp));
            chk("pad_hold",  32'(bus.pipe_hold), 32'(!done_exp));
            chk("pad_ovf",   32'(bus.overflow), 0);
        end

        // A further valid byte after the end must not be taken.
        bus.start      = 1'b0;
        bus.byte_valid = 1'b1;
        bus.byte_last  = 1'b0;
        bus.byte_in    = 8'($urandom);
        tick();
        chk("post_we",    32'(bus.mem_we), 0);
        chk("post_addr",  32'(bus.mem_addr), 32'(exp_addr));
        chk("post_data",  32'(bus.mem_data), 32'(exp_data));
        chk("post_cnt",   32'(bus.byte_count), 32'(idx));
        chk("post_ready", 32'(bus.byte_ready), 0);
        chk("post_done",  32'(bus.load_done), 32'(with_last));
        chk("post_hold",  32'(bus.pipe_hold), 32'(!with_last));
        chk("post_ovf",   32'(bus.overflow), 32'(!with_last));
        bus.byte_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.start      = 1'b0;
        bus.byte_in    = 8'h00;
        bus.byte_valid = 1'b0;
        bus.byte_last  = 1'b0;
        reset          = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check_reset_outputs("rst");
        bus.byte_valid = 1'b1;
        tick();
        check_reset_outputs("idle");
        bus.byte_valid = 1'b0;

        run_load(8, 1'b1, 0);
        run_load(6, 1'b1, 0);
        run_load(4, 1'b1, -1);
        run_load(DEPTH, 1'b0, 0);
        run_load(5, 1'b1, 0);

        // Abandon a load after three bytes.
        bus.start = 1'b1;
        tick();
        bus.start      = 1'b0;
        bus.byte_valid = 1'b1;
        repeat (3) begin
            bus.byte_in = 8'($urandom);
            tick();
        end
        chk("mid_cnt", 32'(bus.byte_count), 3);
        reset = 1'b1;
        tick();
        reset          = 1'b0;
        bus.byte_valid = 1'b0;
        exp_addr       = 0;
        exp_data       = 8'h00;
        check_reset_outputs("midrst");
        run_load(4, 1'b1, 0);

        for (int i = 0; i < 10; i++) begin
            run_load(int'($urandom_range(40, 1)), 1'b1, 30);
        end
        run_load(DEPTH, 1'b1, 20);
        run_load(3, 1'b1, 50);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Program loader that fills the byte-addressed instruction memory from an external byte stream; it is the writer side of the instruction-fetch read path.
- Accepts bytes over a valid/ready handshake and issues byte writes at consecutive addresses from 0.
- Pads a partial final word with NOP bytes so the pipeline never fetches a partial instruction.
- Holds the pipeline (PC/nPC and stage registers) in reset until loading completes.

Parameters:
- ADDR_WIDTH, 9, byte address width of instruction memory.
- DEPTH, 512, memory size in bytes; must be a multiple of 4.
- PAD_BYTE, 8'h00, fill byte for word alignment (all-zero word = NOP).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous reset, active-high.
- start  input  1  single-cycle pulse; begins a load from address 0.
- byte_in  input  8  stream data byte.
- byte_valid  input  1  byte_in is valid.
- byte_last  input  1  qualifies byte_in as the final program byte.
- byte_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  byte write strobe to instruction memory.
- mem_addr  output  ADDR_WIDTH  write byte address.
- mem_data  output  8  write byte.
- byte_count  output  ADDR_WIDTH+1  stream bytes accepted in the current load; excludes pad bytes.
- load_done  output  1  program loaded and word-aligned.
- pipe_hold  output  1  drives the pipeline reset; high while not loaded.
- overflow  output  1  stream exceeded DEPTH without byte_last.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high. All state changes on posedge clk.
- Reset values: state=IDLE, internal pointer ptr=0, byte_count=0, mem_we=0, mem_addr=0, mem_data=0, load_done=0, pipe_hold=1, overflow=0. Memory contents are not touched.
- Outputs: mem_we, mem_addr and mem_data are registered. byte_ready, load_done and pipe_hold are decoded from the state register only (Moore outputs):
  - byte_ready = (state==LOAD)
  - load_done = (state==DONE)
  - pipe_hold = (state!=DONE)
  - overflow is a sticky register.
- Transfer: occurs in a cycle where byte_valid && byte_ready. On the next edge: mem_we=1, mem_addr=ptr, mem_data=byte_in, ptr++, byte_count++. Write latency is 1 cycle. When no transfer or pad write happens, mem_we=0 and mem_addr/mem_data hold their values.
- IDLE:
  - byte_ready=0.
  - start -> LOAD, with ptr=0, byte_count=0, overflow=0.
- LOAD:
  - Transfer with byte_last and ptr[1:0]==3 -> DONE.
  - Transfer with byte_last and ptr[1:0]!=3 -> PAD.
  - Transfer at ptr==DEPTH-1 without byte_last: the byte is still written, then -> ERROR with overflow=1.
  - byte_valid low: remain in LOAD; no write.
  - start is ignored.
- PAD:
  - byte_ready=0.
  - Every cycle: mem_we=1, mem_addr=ptr, mem_data=PAD_BYTE, ptr++. byte_count does not change.
  - The pad write at an address with [1:0]==3 moves the state to DONE on the same edge.
  - Pad writes never exceed DEPTH-1, because DEPTH is a multiple of 4.
  - start is ignored.
- DONE:
  - load_done=1, pipe_hold=0, byte_ready=0. byte_valid is ignored.
  - start -> LOAD; ptr, byte_count and overflow are cleared; pipe_hold returns to 1 on the next cycle.
- ERROR:
  - byte_ready=0, pipe_hold=1, overflow=1.
  - start -> LOAD and clears overflow.
- Simultaneous events:
  - reset has priority over everything.
  - start together with a transfer in LOAD: start is ignored and the transfer is processed.
  - byte_last with a zero-length program cannot occur; at least one transfer precedes any end condition.
- Reset during LOAD or PAD: the load is abandoned, state returns to IDLE, and bytes already written stay in memory.

Test Plan:
- reset, start, stream 8 bytes (last on byte 7) with byte_valid held high -> mem_we for 8 consecutive cycles at addr 0..7 carrying the stream data; load_done=1 and pipe_hold=0 in the cycle of the addr-7 write; byte_count=8.
- Stream 6 bytes, last on byte 5 -> writes to addr 0..5, then pad writes of 8'h00 to addr 6 and 7; load_done rises with the addr-7 write; byte_count=6.
- Stream with byte_valid toggling every other cycle, 4 bytes -> no mem_we in idle-valid cycles; addresses still 0..3, contiguous; done after the 4th byte.
- Stream 513 bytes without byte_last -> bytes 0..511 written; overflow=1 on the edge after the addr-511 transfer; state ERROR with byte_ready=0 and pipe_hold=1; then start -> overflow=0, byte_ready=1, loading restarts at addr 0.
- Assert reset after 3 bytes of a load -> next cycle all outputs at reset values (pipe_hold=1, byte_count=0); a new start reloads from addr 0.
- After DONE, pulse start -> pipe_hold=1 and load_done=0 next cycle; a reload of 4 bytes writes addr 0..3.
